// File: rtl/phys_reg_freelist.sv
// Physical register free list for a register-renaming front end.
//
// Holds the physical registers that are not currently architecturally mapped
// in a circular FIFO. It also keeps the committed (retired) arch->phys map, so
// that a retiring instruction can release the register its destination used
// to map to.
//
// Ports:
//   clk              clock; all state updates on the rising edge
//   rst              synchronous active-high reset; overrides same-cycle traffic
//   alloc_req_i      per-slot request for a free physical destination
//   alloc_ready_o    enough free entries to satisfy every slot this cycle
//   alloc_phys_rd_o  physical register offered to each slot
//   commit_en_i      per-slot retire strobe from the ROB commit side
//   commit_phys_rd_i new physical destination of each retiring instruction
//   commit_arch_rd_i architectural destination of each retiring instruction
//   free_count_o     number of free physical registers held
//   overflow_err_o   sticky overflow/underflow flag, cleared only by rst

module phys_reg_freelist #(
    parameter int unsigned PHYS_REGS      = 64,
    parameter int unsigned ARCH_REGS      = 32,
    parameter int unsigned DISPATCH_WIDTH = 2,
    localparam int unsigned PW            = $clog2(PHYS_REGS),
    localparam int unsigned AW            = $clog2(ARCH_REGS),
    localparam int unsigned FD            = PHYS_REGS - ARCH_REGS,
    localparam int unsigned PTR_W         = $clog2(FD),
    localparam int unsigned CNT_W         = $clog2(FD) + 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DISPATCH_WIDTH-1:0]          alloc_req_i,
    output logic                               alloc_ready_o,
    output logic [DISPATCH_WIDTH-1:0][PW-1:0]  alloc_phys_rd_o,
    input  logic [DISPATCH_WIDTH-1:0]          commit_en_i,
    input  logic [DISPATCH_WIDTH-1:0][PW-1:0]  commit_phys_rd_i,
    input  logic [DISPATCH_WIDTH-1:0][AW-1:0]  commit_arch_rd_i,
    output logic [CNT_W-1:0]                   free_count_o,
    output logic                               overflow_err_o
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0]    fifo_q [FD];
    logic [PW-1:0]    fifo_d [FD];
    logic [PW-1:0]    cmap_q [ARCH_REGS];
    logic [PW-1:0]    cmap_d [ARCH_REGS];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    int unsigned      n_pop;
    int unsigned      n_push;
    int unsigned      n_req;
    logic             alloc_ready;

    // Pointer advance modulo FD. The offset never exceeds DISPATCH_WIDTH, so a
    // single conditional subtract is enough and FD need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                                 input int unsigned      n);
        int unsigned s;
        s = 32'(ptr) + n;
        if (s >= FD) begin
            s = s - FD;
        end
        return PTR_W'(s);
    endfunction

    // ------------------------------------------------------------------
    // Allocation side
    // ------------------------------------------------------------------
    // All-or-nothing: the list only grants when it could serve every slot,
    // so the front end never has to handle a partial grant.
    assign alloc_ready = (32'(count_q) >= DISPATCH_WIDTH);

    // Requesting slots take consecutive entries from the head in slot order;
    // an idle slot is shown the entry the next requesting slot would get.
    always_comb begin
        n_req = 0;
        for (int unsigned w = 0; w < DISPATCH_WIDTH; w++) begin
            alloc_phys_rd_o[w] = fifo_q[ptr_add(rd_ptr_q, n_req)];
            if (alloc_req_i[w]) begin
                n_req = n_req + 1;
            end
        end
        n_pop = alloc_ready ? n_req : 0;
    end

    // ------------------------------------------------------------------
    // Commit side
    // ------------------------------------------------------------------
    // Slots are walked in order against the running copy cmap_d, so a later
    // slot writing the same arch register releases what the earlier slot just
    // installed. Arch register 0 is never renamed and is skipped entirely.
    always_comb begin
        cmap_d = cmap_q;
        fifo_d = fifo_q;
        n_push = 0;
        for (int unsigned w = 0; w < DISPATCH_WIDTH; w++) begin
            if (commit_en_i[w] && (commit_arch_rd_i[w] != '0)) begin
                fifo_d[ptr_add(wr_ptr_q, n_push)] = cmap_d[commit_arch_rd_i[w]];
                cmap_d[commit_arch_rd_i[w]]       = commit_phys_rd_i[w];
                n_push                            = n_push + 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy and error tracking
    // ------------------------------------------------------------------
    // Pushed entries land in fifo_q only at the edge and count_q only grows
    // then, so a register freed this cycle cannot be handed out this cycle.
    always_comb begin
        rd_ptr_d = ptr_add(rd_ptr_q, n_pop);
        wr_ptr_d = ptr_add(wr_ptr_q, n_push);
        count_d  = count_q + CNT_W'(n_push) - CNT_W'(n_pop);
        err_d    = err_q
                 | ((32'(count_q) + n_push) > (FD + n_pop))
                 | (n_pop > 32'(count_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FD; i++) begin
                fifo_q[i] <= PW'(ARCH_REGS + i);
            end
            for (int unsigned i = 0; i < ARCH_REGS; i++) begin
                cmap_q[i] <= PW'(i);
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= CNT_W'(FD);
            err_q    <= 1'b0;
        end else begin
            fifo_q   <= fifo_d;
            cmap_q   <= cmap_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign alloc_ready_o  = alloc_ready;
    assign free_count_o   = count_q;
    assign overflow_err_o = err_q;

endmodule

// File: tb/tb_phys_reg_freelist.sv
// Scoreboard bench for phys_reg_freelist: the driver applies one vector per
// cycle and queues the outputs expected for that cycle; the monitor pops and
// compares on the falling edge.

module tb_phys_reg_freelist;

    logic            clk;
    logic            rst;
    logic [1:0]      alloc_req;
    logic            alloc_ready;
    logic [1:0][5:0] alloc_phys_rd;
    logic [1:0]      commit_en;
    logic [1:0][5:0] commit_phys_rd;
    logic [1:0][4:0] commit_arch_rd;
    logic [5:0]      free_count;
    logic            overflow_err;

    phys_reg_freelist dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_req_i      (alloc_req),
        .alloc_ready_o    (alloc_ready),
        .alloc_phys_rd_o  (alloc_phys_rd),
        .commit_en_i      (commit_en),
        .commit_phys_rd_i (commit_phys_rd),
        .commit_arch_rd_i (commit_arch_rd),
        .free_count_o     (free_count),
        .overflow_err_o   (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mask[0]: check slot0 phys, mask[1]: slot1 phys, mask[2]: free_count
    typedef struct {
        logic [2:0] mask;
        int         rdy;
        int         p0;
        int         p1;
        int         cnt;
        int         err;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];
    int    checks = 0;
    int    errors = 0;
    logic  done   = 1'b0;

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            logic  bad;
            e   = exp_q.pop_front();
            n   = name_q.pop_front();
            bad = (int'(alloc_ready) != e.rdy) || (int'(overflow_err) != e.err);
            if (e.mask[0] && (int'(alloc_phys_rd[0]) != e.p0)) bad = 1'b1;
            if (e.mask[1] && (int'(alloc_phys_rd[1]) != e.p1)) bad = 1'b1;
            if (e.mask[2] && (int'(free_count) != e.cnt)) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s: got rdy=%0d p0=%0d p1=%0d cnt=%0d err=%0d want rdy=%0d p0=%0d p1=%0d cnt=%0d err=%0d mask=%b",
                         n, alloc_ready, alloc_phys_rd[0], alloc_phys_rd[1], free_count,
                         overflow_err, e.rdy, e.p0, e.p1, e.cnt, e.err, e.mask);
            end
        end
    end

    task automatic set_commit(input logic [1:0] en, input int a0, input int ph0,
                              input int a1, input int ph1);
        commit_en         = en;
        commit_arch_rd[0] = 5'(a0);
        commit_phys_rd[0] = 6'(ph0);
        commit_arch_rd[1] = 5'(a1);
        commit_phys_rd[1] = 6'(ph1);
    endtask

    // Called just after a rising edge: drive one cycle, queue its expectation.
    task automatic step(input string nm, input logic [1:0] areq, input logic [2:0] m,
                        input int rdy, input int p0, input int p1, input int cnt,
                        input int err);
        exp_t e;
        alloc_req = areq;
        e.mask = m; e.rdy = rdy; e.p0 = p0; e.p1 = p1; e.cnt = cnt; e.err = err;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        alloc_req = 2'b00;
        set_commit(2'b00, 0, 0, 0, 0);
    endtask

    // Reset with junk traffic that must be discarded.
    task automatic do_reset();
        rst       = 1'b1;
        alloc_req = 2'b11;
        set_commit(2'b11, 5, 50, 6, 51);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        alloc_req = 2'b00;
        set_commit(2'b00, 0, 0, 0, 0);
    endtask

    initial begin
        do_reset();

        // Pair allocation straight after reset, then the next pair
        step("rst_alloc11", 2'b11, 3'b111, 1, 32, 33, 32, 0);
        step("second_pair", 2'b11, 3'b111, 1, 34, 35, 30, 0);
        step("idle_head",   2'b00, 3'b101, 1, 36, 0,  28, 0);

        // Single-slot allocations take consecutive entries
        do_reset();
        step("slot1_only",  2'b10, 3'b110, 1, 0,  32, 32, 0);
        step("slot0_only",  2'b01, 3'b101, 1, 33, 0,  31, 0);
        step("after_single",2'b00, 3'b100, 1, 0,  0,  30, 0);

        // Commits: single, same-arch pair, arch 0 ignored, slot1-only
        do_reset();
        step("c_alloc0", 2'b11, 3'b111, 1, 32, 33, 32, 0);
        step("c_alloc1", 2'b11, 3'b111, 1, 34, 35, 30, 0);
        step("c_alloc2", 2'b11, 3'b111, 1, 36, 37, 28, 0);
        set_commit(2'b01, 5, 40, 0, 0);
        step("commit_a5",     2'b00, 3'b101, 1, 38, 0, 26, 0);
        set_commit(2'b11, 7, 40, 7, 41);
        step("commit_a7_a7",  2'b00, 3'b101, 1, 38, 0, 27, 0);
        set_commit(2'b11, 0, 50, 0, 51);
        step("commit_arch0",  2'b00, 3'b101, 1, 38, 0, 29, 0);
        set_commit(2'b11, 0, 52, 9, 44);
        step("commit_s1_a9",  2'b00, 3'b101, 1, 38, 0, 29, 0);
        // Drain through the wrap; pushed 5,7,40,9 appear in order
        for (int k = 0; k < 13; k++) begin
            step("drain", 2'b11, 3'b111, 1, 38 + 2 * k, 39 + 2 * k, 30 - 2 * k, 0);
        end
        step("pushed_5_7",  2'b11, 3'b111, 1, 5,  7, 4, 0);
        step("pushed_40",   2'b01, 3'b101, 1, 40, 0, 2, 0);
        // One entry left: no grant, but a same-cycle commit still pushes
        set_commit(2'b01, 3, 20, 0, 0);
        step("stall_cnt1",  2'b11, 3'b101, 0, 9,  0, 1, 0);
        step("after_stall", 2'b11, 3'b111, 1, 9,  3, 2, 0);
        step("empty",       2'b00, 3'b100, 0, 0,  0, 0, 0);

        // Full wrap: 16 alloc-all cycles, 16 commit-pair cycles, reallocate
        do_reset();
        for (int k = 0; k < 16; k++) begin
            step("wrap_alloc", 2'b11, 3'b111, 1, 32 + 2 * k, 33 + 2 * k, 32 - 2 * k, 0);
        end
        for (int j = 0; j < 16; j++) begin
            set_commit(2'b11, j + 1, 32 + 2 * j, (j < 15) ? j + 17 : 16, 33 + 2 * j);
            step("wrap_commit", 2'b00, 3'b100, (j >= 1) ? 1 : 0, 0, 0, 2 * j, 0);
        end
        set_commit(2'b11, 0, 50, 0, 51);
        step("wrap_full_arch0", 2'b00, 3'b100, 1, 0, 0, 32, 0);
        for (int k = 0; k < 16; k++) begin
            step("wrap_realloc", 2'b11, 3'b111, 1, (k < 15) ? k + 1 : 16,
                 (k < 15) ? k + 17 : 62, 32 - 2 * k, 0);
        end
        step("wrap_empty", 2'b00, 3'b100, 0, 0, 0, 0, 0);

        // Overflow: commit into a full list; flag is sticky until reset
        do_reset();
        set_commit(2'b01, 1, 40, 0, 0);
        step("ovf_push",   2'b00, 3'b100, 1, 0, 0, 32, 0);
        step("ovf_set",    2'b00, 3'b000, 1, 0, 0, 0,  1);
        step("ovf_sticky", 2'b00, 3'b000, 1, 0, 0, 0,  1);
        do_reset();
        step("ovf_cleared", 2'b11, 3'b111, 1, 32, 33, 32, 0);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout: got no completion, want completion");
            $fatal(1, "timeout");
        end
    end

endmodule
